// File: rtl/imm_gen_stage_pkg.sv
// rtl/imm_gen_stage_pkg.sv - shared instruction defines, format codes and decode helpers
`ifndef IMM_GEN_DEFINES_SVH
`define IMM_GEN_DEFINES_SVH
`define INST_WIDTH 32
`define OPCODE     6:0
`define FUNCT3     14:12

`define OPC_LOAD   7'b0000011
`define OPC_ALUI   7'b0010011
`define OPC_AUIPC  7'b0010111
`define OPC_ALUIW  7'b0011011
`define OPC_STORE  7'b0100011
`define OPC_OP     7'b0110011
`define OPC_LUI    7'b0110111
`define OPC_OPW    7'b0111011
`define OPC_BRANCH 7'b1100011
`define OPC_JALR   7'b1100111
`define OPC_JAL    7'b1101111
`define OPC_SYSTEM 7'b1110011

`define FMT_R 3'd0
`define FMT_I 3'd1
`define FMT_S 3'd2
`define FMT_B 3'd3
`define FMT_U 3'd4
`define FMT_J 3'd5
`define FMT_Z 3'd6
`define FMT_X 3'd7
`endif

package imm_gen_stage_pkg;

    localparam logic [15:0] ILLEGAL_CNT_MAX = 16'hFFFF;

    // funct3 001 (sll) and 101 (srl/sra) carry a shift amount instead of an immediate
    function automatic logic is_shift_imm(input logic [2:0] funct3);
        return funct3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate/format decoder
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [`INST_WIDTH-1:0] inst,
    output logic [XLEN-1:0]        imm,
    output logic [2:0]             fmt,
    output logic                   illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = inst[`OPCODE];
    assign funct3 = inst[`FUNCT3];

    always_comb begin
        imm     = '0;
        fmt     = `FMT_X;
        illegal = 1'b0;
        case (opcode)
            `OPC_LOAD, `OPC_JALR: begin
                fmt = `FMT_I;
                imm = XLEN'($signed(inst[31:20]));
            end
            `OPC_ALUI: begin
                fmt = `FMT_I;
                if (is_shift_imm(funct3))
                    imm = RV64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
                else
                    imm = XLEN'($signed(inst[31:20]));
            end
            `OPC_ALUIW: begin
                if (RV64) begin
                    fmt = `FMT_I;
                    if (is_shift_imm(funct3))
                        imm = XLEN'(inst[24:20]);
                    else
                        imm = XLEN'($signed(inst[31:20]));
                end else begin
                    illegal = 1'b1;
                end
            end
            `OPC_SYSTEM: begin
                // funct3[2] selects the CSR immediate forms, whose rs1 field is a zimm
                if (funct3[2]) begin
                    fmt = `FMT_Z;
                    imm = XLEN'(inst[19:15]);
                end else begin
                    fmt = `FMT_I;
                    imm = XLEN'($signed(inst[31:20]));
                end
            end
            `OPC_STORE: begin
                fmt = `FMT_S;
                imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            `OPC_BRANCH: begin
                fmt = `FMT_B;
                imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            `OPC_LUI, `OPC_AUIPC: begin
                fmt = `FMT_U;
                imm = XLEN'($signed({inst[31:12], 12'b0}));
            end
            `OPC_JAL: begin
                fmt = `FMT_J;
                imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            `OPC_OP: begin
                fmt = `FMT_R;
            end
            `OPC_OPW: begin
                if (RV64)
                    fmt = `FMT_R;
                else
                    illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            fmt = `FMT_X;
            imm = '0;
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - immediate generation stage with valid/ready handshake and optional skid
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [`INST_WIDTH-1:0] i_inst,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [XLEN-1:0]        o_imm,
    output logic [2:0]             o_fmt,
    output logic                   o_illegal,
    output logic [15:0]            o_illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .inst    (i_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    logic            out_valid;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_ill;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_ill;
    logic [15:0]     ill_cnt;
    logic            in_fire;
    logic            out_fire;

    // Reset masks the handshake immediately so nothing transfers in a reset cycle
    assign o_valid  = out_valid && !i_rst;
    assign o_ready  = !i_rst && ((SKID_EN != 0) ? !skid_valid : (!out_valid || i_ready));
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    assign o_imm         = out_imm;
    assign o_fmt         = out_fmt;
    assign o_illegal     = out_ill;
    assign o_illegal_cnt = ill_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= '0;
            out_ill    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= '0;
            skid_ill   <= 1'b0;
            ill_cnt    <= '0;
        end else begin
            if (in_fire && dec_ill && ill_cnt != ILLEGAL_CNT_MAX)
                ill_cnt <= ill_cnt + 16'd1;

            if (skid_valid) begin
                // o_ready is low while the skid is full, so only a drain can happen here
                if (out_fire) begin
                    out_imm    <= skid_imm;
                    out_fmt    <= skid_fmt;
                    out_ill    <= skid_ill;
                    skid_valid <= 1'b0;
                end
            end else if (in_fire) begin
                if (!out_valid || out_fire) begin
                    out_valid <= 1'b1;
                    out_imm   <= dec_imm;
                    out_fmt   <= dec_fmt;
                    out_ill   <= dec_ill;
                end else if (SKID_EN != 0) begin
                    skid_valid <= 1'b1;
                    skid_imm   <= dec_imm;
                    skid_fmt   <= dec_fmt;
                    skid_ill   <= dec_ill;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench for imm_gen_stage (RV32/RV64 skid, RV32 plain register)
module tb_imm_gen_stage;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        rst_d = 1'b0;

    logic        r32, v32, ill32, r64, v64, ill64, r0, v0, ill0;
    logic [31:0] imm32, imm0;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64, fmt0;
    logic [15:0] cnt32, cnt64, cnt0;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[3][$];
    int   mcnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .SKID_EN(1)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(r32), .i_inst(inst),
        .o_valid(v32), .i_ready(out_ready), .o_imm(imm32), .o_fmt(fmt32),
        .o_illegal(ill32), .o_illegal_cnt(cnt32)
    );

    imm_gen_stage #(.XLEN(64), .SKID_EN(1)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(r64), .i_inst(inst),
        .o_valid(v64), .i_ready(out_ready), .o_imm(imm64), .o_fmt(fmt64),
        .o_illegal(ill64), .o_illegal_cnt(cnt64)
    );

    imm_gen_stage #(.XLEN(32), .SKID_EN(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(r0), .i_inst(inst),
        .o_valid(v0), .i_ready(out_ready), .o_imm(imm0), .o_fmt(fmt0),
        .o_illegal(ill0), .o_illegal_cnt(cnt0)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic longint sx(input longint v, input int bits);
        return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    endfunction

    // Reference decode: field values assembled arithmetically, then wrapped to XLEN
    function automatic exp_t model(input logic [31:0] w, input int xlen);
        exp_t   e;
        longint v;
        int     op;
        int     f3;
        longint i_imm;
        op    = int'(w[6:0]);
        f3    = int'(w[14:12]);
        i_imm = sx(longint'(w[31:20]), 12);
        v     = 0;
        e.fmt = 3'd7;
        e.ill = 1'b0;
        case (op)
            'h03, 'h67: begin e.fmt = 3'd1; v = i_imm; end
            'h13, 'h1b: begin
                if (op == 'h1b && xlen == 32) e.ill = 1'b1;
                else begin
                    e.fmt = 3'd1;
                    if (f3 == 1 || f3 == 5)
                        v = (op == 'h13 && xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
                    else
                        v = i_imm;
                end
            end
            'h73: begin
                if (f3 >= 4) begin e.fmt = 3'd6; v = longint'(w[19:15]); end
                else begin e.fmt = 3'd1; v = i_imm; end
            end
            'h23: begin
                e.fmt = 3'd2;
                v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
            end
            'h63: begin
                e.fmt = 3'd3;
                v = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                       longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            end
            'h37, 'h17: begin
                e.fmt = 3'd4;
                v = sx(longint'(w[31:12]) * 4096, 32);
            end
            'h6f: begin
                e.fmt = 3'd5;
                v = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                       longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            end
            'h33: e.fmt = 3'd0;
            'h3b: begin
                if (xlen == 32) e.ill = 1'b1;
                else e.fmt = 3'd0;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.fmt = 3'd7;
            v = 0;
        end
        e.imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: w[6:0] = 7'h03;   1: w[6:0] = 7'h13;   2: w[6:0] = 7'h17;
            3: w[6:0] = 7'h1b;   4: w[6:0] = 7'h23;   5: w[6:0] = 7'h33;
            6: w[6:0] = 7'h37;   7: w[6:0] = 7'h3b;   8: w[6:0] = 7'h63;
            9: w[6:0] = 7'h67;  10: w[6:0] = 7'h6f;  11: w[6:0] = 7'h73;
            12: w[6:0] = 7'h7f;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_dut(input int id, input int xlen, input bit skid,
                             input logic rdy, input logic vld, input logic [63:0] imm,
                             input logic [2:0] fmt, input logic ill, input logic [15:0] cnt);
        exp_t e;
        logic exp_rdy;
        if (rst_d) begin
            chk($sformatf("d%0d_rst_imm", id), imm, 64'd0);
            chk($sformatf("d%0d_rst_fmt", id), 64'(fmt), 64'd0);
            chk($sformatf("d%0d_rst_ill", id), 64'(ill), 64'd0);
            chk($sformatf("d%0d_rst_cnt", id), 64'(cnt), 64'd0);
        end
        if (rst) begin
            chk($sformatf("d%0d_rst_valid", id), 64'(vld), 64'd0);
            chk($sformatf("d%0d_rst_ready", id), 64'(rdy), 64'd0);
            q[id].delete();
            mcnt[id] = 0;
            return;
        end
        chk($sformatf("d%0d_illegal_cnt", id), 64'(cnt), 64'(mcnt[id]));
        exp_rdy = skid ? (q[id].size() < 2) : (q[id].size() == 0 || out_ready);
        chk($sformatf("d%0d_ready", id), 64'(rdy), 64'(exp_rdy));
        chk($sformatf("d%0d_valid", id), 64'(vld), 64'(q[id].size() != 0));
        if (vld && q[id].size() != 0) begin
            e = q[id][0];
            chk($sformatf("d%0d_imm", id), imm, e.imm);
            chk($sformatf("d%0d_fmt", id), 64'(fmt), 64'(e.fmt));
            chk($sformatf("d%0d_illegal", id), 64'(ill), 64'(e.ill));
            if (out_ready) void'(q[id].pop_front());
        end
        if (in_valid && exp_rdy) begin
            e = model(inst, xlen);
            q[id].push_back(e);
            if (e.ill && mcnt[id] < 65535) mcnt[id]++;
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, 32, 1'b1, r32, v32, 64'(imm32), fmt32, ill32, cnt32);
        check_dut(1, 64, 1'b1, r64, v64, imm64,      fmt64, ill64, cnt64);
        check_dut(2, 32, 1'b0, r0,  v0,  64'(imm0),  fmt0,  ill0,  cnt0);
        rst_d = rst;
    end

    task automatic directed(input int id, input logic [31:0] w,
                            input logic [63:0] eimm, input logic [2:0] efmt);
        @(posedge clk); #1;
        in_valid = 1'b1; inst = w; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        if (id == 1) begin
            chk($sformatf("kat64_%h_valid", w), 64'(v64), 64'd1);
            chk($sformatf("kat64_%h_imm", w), imm64, eimm);
            chk($sformatf("kat64_%h_fmt", w), 64'(fmt64), 64'(efmt));
        end else begin
            chk($sformatf("kat32_%h_valid", w), 64'(v32), 64'd1);
            chk($sformatf("kat32_%h_imm", w), 64'(imm32), eimm);
            chk($sformatf("kat32_%h_fmt", w), 64'(fmt32), 64'(efmt));
        end
    endtask

    initial begin
        int  nv;
        logic acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inst = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        directed(0, 32'h80000013, 64'hFFFFF800, 3'd1);
        directed(0, 32'hFE4104E3, 64'hFFFFFFE8, 3'd3);
        directed(0, 32'hF19FF26F, 64'hFFFFFF18, 3'd5);
        directed(0, 32'h40315093, 64'h3, 3'd1);
        directed(0, 32'h3402D073, 64'h5, 3'd6);
        directed(0, 32'h00F80023, 64'h0, 3'd2);
        directed(1, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
        directed(1, 32'h000170B7, 64'h0000000000017000, 3'd4);

        repeat (3) directed(0, 32'h0000007F, 64'h0, 3'd7);
        chk("illegal_cnt_3", 64'(cnt32), 64'd3);
        chk("illegal_flag", 64'(ill32), 64'd1);

        @(posedge clk); #1;
        in_valid = 1'b1; inst = 32'h0000007F; out_ready = 1'b1;
        repeat (65534) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("illegal_cnt_full", 64'(cnt32), 64'hFFFF);
        directed(0, 32'h0000007F, 64'h0, 3'd7);
        chk("illegal_cnt_sat", 64'(cnt32), 64'hFFFF);

        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h0000007F;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("full_ready", 64'(r32), 64'd0);
        chk("full_valid", 64'(v32), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_full_valid", 64'(v32), 64'd0);
        chk("rst_full_ready", 64'(r32), 64'd0);
        chk("rst_full_cnt", 64'(cnt32), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(r32), 64'd1);

        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00500093;
        @(posedge clk); #1 inst = 32'hFFF00113;
        @(posedge clk); #1 inst = 32'h01A00193;
        @(negedge clk);
        chk("skid_ready_drop", 64'(r32), 64'd0);
        chk("skid_valid_held", 64'(v32), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            @(negedge clk);
            acc = r32;
            @(posedge clk); #1;
        end
        chk("skid_c_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        nv = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inst = rand_inst();
            @(negedge clk);
            if (i > 0 && v32) nv++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (v32) nv++;
        chk("throughput", 64'(nv), 64'd8);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            inst      = rand_inst();
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drained32", 64'(q[0].size()), 64'd0);
        chk("drained64", 64'(q[1].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
